// File: rtl/tt_stim_checker.sv
// tt_stim_checker: exhaustive truth-table driver/checker for an N_IN-input, 1-output combinational DUT.
module tt_stim_checker #(
    parameter int                  N_IN   = 3,
    parameter int                  HOLD   = 20,
    parameter logic [2**N_IN-1:0]  EXP_TT = 8'b1110_1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_f,
    output logic [N_IN-1:0] x,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] fev_q, fev_d;
    logic            fevv_q, fevv_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            smp, mis, last;

    assign smp  = (state_q == APPLY) && (hold_q == HW'(HOLD - 1));
    assign mis  = smp && (dut_f != EXP_TT[vec_q]);
    assign last = (vec_q == {N_IN{1'b1}});

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fevv_d  = fevv_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        if (state_q != APPLY && start) begin
            state_d = APPLY;
            vec_d   = '0;
            hold_d  = '0;
            err_d   = '0;
            fev_d   = '0;
            fevv_d  = 1'b0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else if (state_q == APPLY) begin
            hold_d = smp ? '0 : hold_q + 1'b1;
            err_d  = mis ? err_q + 1'b1 : err_q;
            fev_d  = (mis && !fevv_q) ? vec_q : fev_q;
            fevv_d = fevv_q | mis;
            // the terminal compare finishes the run instead of wrapping vec
            if (smp && last) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_d == '0);
            end else if (smp) begin
                vec_d = vec_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            err_q   <= '0;
            fev_q   <= '0;
            fevv_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fevv_q  <= fevv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign x               = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fevv_q;
endmodule

// File: tb/tb_tt_stim_checker.sv
// tb_tt_stim_checker: randomized truth-table runs against a per-vector reference model.
module tb_tt_stim_checker;
    localparam int N_IN = 3;
    localparam int HOLD = 20;
    localparam int NV   = 2**N_IN;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            dut_f = 1'b0;
    logic [N_IN-1:0] x;
    logic            busy, done, pass, first_err_valid;
    logic [N_IN:0]   err_cnt;
    logic [N_IN-1:0] first_err_vec;

    int n_cmp = 0;
    int n_bad = 0;

    tt_stim_checker #(.N_IN(N_IN), .HOLD(HOLD), .EXP_TT(8'b1110_1000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_f(dut_f), .x(x),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_vec(first_err_vec), .first_err_valid(first_err_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic maj(input int v);
        return ((v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1)) >= 2;
    endfunction

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_pass", pass, 0);
        chk("start_err", err_cnt, 0);
        chk("start_fev", first_err_valid, 0);
    endtask

    // flip: vectors whose sampled value is wrong; glitch: random dut_f off the sample cycle
    task automatic run(input logic [7:0] flip, input bit glitch, input int restart_at, input string tag);
        int exp_err = 0;
        int exp_first = 0;
        for (int v = NV - 1; v >= 0; v--) if (flip[v]) begin exp_err++; exp_first = v; end
        start_pulse();
        for (int k = 1; k <= NV * HOLD; k++) begin
            int v = (k - 1) / HOLD;
            logic good = maj(v);
            dut_f = (k % HOLD == 0) ? good ^ flip[v] : (glitch ? 1'($urandom) : good);
            start = (k == restart_at);
            chk({tag, "_x"}, x, v);
            chk({tag, "_busydone"}, {busy, done}, 2'b10);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pass"}, pass, exp_err == 0);
        chk({tag, "_err"}, err_cnt, exp_err);
        chk({tag, "_fevv"}, first_err_valid, exp_err != 0);
        if (exp_err != 0) chk({tag, "_fev"}, first_err_vec, exp_first);
        chk({tag, "_xlast"}, x, NV - 1);
        repeat (5) @(posedge clk);
        #1 chk({tag, "_hold"}, {done, pass}, {1'b1, exp_err == 0});
    endtask

    initial begin
        #1;
        chk("rst_x", x, 0);
        chk("rst_out", {busy, done, pass, first_err_valid}, 0);
        chk("rst_err", err_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("idle_x", x, 0);
        chk("idle_busy", busy, 0);
        run(8'h00, 0, 0, "maj");
        run(8'hFF, 0, 0, "inv");
        run(8'h20, 0, 0, "f5");
        run(8'h48, 0, 0, "f36");
        run(8'h00, 1, 0, "glitch");
        run(8'h00, 0, 50, "restart50");
        run(8'h00, 0, 0, "from_done");
        for (int i = 0; i < 4; i++) run(8'($urandom), 1, int'($urandom_range(1, NV * HOLD - 1)), "rand");
        start_pulse();
        for (int k = 1; k <= 3 * HOLD + 5; k++) begin
            dut_f = maj((k - 1) / HOLD);
            @(posedge clk);
            #1;
        end
        chk("pre_abort_x", x, 3);
        #3 rst_n = 1'b0;
        #1 chk("abort_x", x, 0);
        chk("abort_out", {busy, done, pass, first_err_valid}, 0);
        chk("abort_err", err_cnt, 0);
        chk("abort_fev", first_err_vec, 0);
        @(negedge clk) rst_n = 1'b1;
        run(8'h00, 0, 0, "after_abort");
        run(8'h11, 0, 0, "fail_again");
        run(8'h00, 0, 0, "restart_ok");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tt_stim_checker.md
Name: tt_stim_checker

Overview:
- Synthesizable self-checking driver for an N_IN-input, 1-output combinational function under test.
- Steps x through all 2^N_IN input vectors in ascending binary order, 0 first.
- Holds each vector for HOLD clock cycles, then samples the DUT output and compares it against the expected truth table.
- Reports mismatch count, first failing vector and a pass flag. Used as the on-board checker for the lab combinational tasks.

Parameters:
- N_IN, 3, number of DUT inputs; legal range 1..8.
- HOLD, 20, clock cycles each vector is applied; legal minimum 2.
- EXP_TT, 8'b1110_1000, expected truth table, width 2^N_IN; bit v is the expected dut_f for x==v (default is 3-input majority).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a run; sampled on the rising edge.
- dut_f  in  1  DUT output.
- x  out  N_IN  stimulus vector driven to the DUT.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next start or reset.
- pass  out  1  done && err_cnt==0; 0 whenever done==0.
- err_cnt  out  N_IN+1  number of mismatching vectors in the last or current run.
- first_err_vec  out  N_IN  vector index of the first mismatch.
- first_err_valid  out  1  first_err_vec holds a valid index.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - x, busy, done, pass, err_cnt, first_err_vec and first_err_valid all go to 0.
  - The internal vector counter and hold counter clear.
- States: IDLE, APPLY, DONE. All outputs are registered.
- IDLE:
  - x=0.
  - start=1 -> APPLY at that edge: vec=0, hold_cnt=0, err_cnt=0, first_err_valid=0, first_err_vec=0, busy=1.
- APPLY:
  - x=vec.
  - hold_cnt increments every cycle.
  - On the edge where hold_cnt==HOLD-1, dut_f is compared with EXP_TT[vec]:
    - If they mismatch, err_cnt increments.
    - If they mismatch and first_err_valid==0, first_err_vec=vec and first_err_valid=1.
  - After the compare, hold_cnt clears. Then:
    - If vec<2^N_IN-1: vec increments and the state stays APPLY.
    - Else: go to DONE; busy=0, done=1.
  - Only the sample edge is compared. dut_f glitches earlier in the hold window are ignored.
- DONE:
  - x holds the last vector (2^N_IN-1).
  - done=1 and pass=(err_cnt==0) hold indefinitely.
  - start=1 -> restart exactly as from IDLE, clearing done, pass and all error results at that edge.
- Timing: if start is sampled at edge E0, then
  - x==v during the cycles after edge E0+v*HOLD;
  - vector v is sampled at edge E0+(v+1)*HOLD;
  - done rises at edge E0+2^N_IN*HOLD (160 cycles for the defaults).
- start while busy (APPLY) is ignored; the run is neither restarted nor perturbed.
- err_cnt width N_IN+1 holds the maximum value 2^N_IN exactly; no saturation is needed.
- A reset mid-run aborts the run immediately, with all outputs at their reset values. The next start begins a clean run.
- Counter wrap: vec never wraps past 2^N_IN-1. The terminal compare moves the state to DONE instead of incrementing vec.

Test Plan:
- Defaults; dut_f driven as majority(x) -> x steps 0..7, 20 cycles each; done=1 160 cycles after start; pass=1, err_cnt=0, first_err_valid=0.
- dut_f = ~majority(x) -> done after 160 cycles; err_cnt=8, first_err_vec=0, first_err_valid=1, pass=0.
- Single fault: dut_f correct except forced 0 when x==5 -> err_cnt=1, first_err_vec=5, pass=0. Also force x==3 and x==6 wrong -> err_cnt=2, first_err_vec=3.
- Glitch immunity: dut_f wrong for the first 19 cycles of every vector, correct on the sample cycle -> pass=1, err_cnt=0.
- Control robustness:
  - Pulse start again at cycle 50 of a run -> no effect; done still at cycle 160.
  - Assert rst_n=0 while x==3 -> all outputs 0 asynchronously.
  - A new start then completes with pass=1 for a correct DUT.
- Restart from DONE after a failing run, now with a correct DUT -> done, pass and err_cnt clear at the start edge; the final result is pass=1, err_cnt=0.
